// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_scheduler_pkg
// Brief   : Shared state encoding and header helpers for the UART TX scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_HDR       = 3'd2,
        ST_FETCH     = 3'd3,
        ST_LOAD      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_END       = 3'd6,
        ST_ABORT     = 3'd7
    } state_t;

    localparam logic [7:0] HDR_IDX_MASK = 8'h07;

    // Source index occupies the low three bits of the header byte.
    function automatic logic [7:0] header_byte(input logic [7:0] base, input logic [2:0] idx);
        return (base & ~HDR_IDX_MASK) | {5'b00000, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first request at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = IDX_W'(cand);
            if (!any_o && req_i[cidx]) begin
                any_o         = 1'b1;
                idx_o         = cidx;
                grant_o[cidx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin sharing of one UART transmitter between requesters.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int         NUM_REQ       = 4,
    parameter bit         HEADER_EN     = 1'b1,
    parameter logic [7:0] HEADER_BASE   = 8'hA0,
    parameter int         START_TIMEOUT = 2048
) (
    input  logic                   clockIN,
    input  logic                   nResetIN,
    input  logic [NUM_REQ*8-1:0]   reqDataIN,
    input  logic [NUM_REQ-1:0]     reqValidIN,
    input  logic [NUM_REQ-1:0]     reqLastIN,
    output logic [NUM_REQ-1:0]     reqReadyOUT,
    output logic [NUM_REQ-1:0]     grantOUT,
    output logic                   busyOUT,
    output logic                   errorOUT,
    input  logic                   errClearIN,
    output logic [7:0]             txDataOUT,
    output logic                   txLoadOUT,
    input  logic                   txReadyIN,
    input  logic                   txIdleIN
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    logic               rdy_meta_q, rdy_s_q, idle_meta_q, idle_s_q;
    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q, gidx_q;
    logic [NUM_REQ-1:0] grant_q, ready_q;
    logic               busy_q, err_q, load_q, last_q, hdr_q;
    logic [7:0]         data_q;
    logic [TMR_W-1:0]   timer_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (reqValidIN),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Transmitter status lives in the baud domain.
    always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN) begin
            rdy_meta_q  <= 1'b0;
            rdy_s_q     <= 1'b0;
            idle_meta_q <= 1'b0;
            idle_s_q    <= 1'b0;
        end else begin
            rdy_meta_q  <= txReadyIN;
            rdy_s_q     <= rdy_meta_q;
            idle_meta_q <= txIdleIN;
            idle_s_q    <= idle_meta_q;
        end
    end

    always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            ready_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            last_q  <= 1'b0;
            hdr_q   <= 1'b0;
            data_q  <= '0;
            timer_q <= '0;
        end else begin
            ready_q <= '0;
            // A timeout later in this block overrides the clear.
            if (errClearIN) begin
                err_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (|reqValidIN && rdy_s_q && idle_s_q) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (arb_any) begin
                        grant_q <= arb_grant;
                        gidx_q  <= arb_idx;
                        busy_q  <= 1'b1;
                        hdr_q   <= 1'b0;
                        state_q <= HEADER_EN ? ST_HDR : ST_FETCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    data_q  <= header_byte(HEADER_BASE, 3'(gidx_q));
                    last_q  <= 1'b0;
                    hdr_q   <= 1'b1;
                    load_q  <= 1'b1;
                    timer_q <= '0;
                    state_q <= ST_LOAD;
                end
                ST_FETCH: begin
                    if (reqValidIN[gidx_q]) begin
                        data_q  <= reqDataIN[{gidx_q, 3'b000} +: 8];
                        last_q  <= reqLastIN[gidx_q];
                        ready_q <= grant_q;
                        load_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!rdy_s_q) begin
                        load_q  <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end else if (timer_q == TMR_W'(START_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        load_q  <= 1'b0;
                        state_q <= ST_ABORT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (rdy_s_q) begin
                        if (hdr_q || !last_q) begin
                            hdr_q   <= 1'b0;
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_END;
                        end
                    end
                end
                ST_END, ST_ABORT: begin
                    ptr_q   <= (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign reqReadyOUT = ready_q;
    assign grantOUT    = grant_q;
    assign busyOUT     = busy_q;
    assign errorOUT    = err_q;
    assign txDataOUT   = data_q;
    assign txLoadOUT   = load_q;

endmodule
`default_nettype wire
